// File: rtl/player_move_ctrl.sv
// Purpose : moves the maze player one cell per accepted tick, checks the wall map, then erases and redraws the player.
// Latency : an accepted tick reaches ERASE after 1 + MEM_LATENCY cycles; each plot then waits for draw_ack.
// Backpr. : plot requests hold steady until draw_ack; ticks arriving outside IDLE are dropped, never queued.
module player_move_ctrl #(
    parameter int MAX_X       = 39,
    parameter int MAX_Y       = 29,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int EXIT_X      = 39,
    parameter int EXIT_Y      = 29,
    parameter int MEM_LATENCY = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic [3:0] dir,
    output logic [5:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_data,
    output logic       draw_req,
    output logic       draw_erase,
    output logic [5:0] draw_x,
    output logic [4:0] draw_y,
    input  logic       draw_ack,
    output logic [5:0] pos_x,
    output logic [4:0] pos_y,
    output logic       busy,
    output logic       won
);

    localparam int              CW       = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_LATENCY);
    localparam logic [5:0]      MAXX     = 6'(MAX_X);
    localparam logic [4:0]      MAXY     = 5'(MAX_Y);
    localparam logic [5:0]      STX      = 6'(START_X);
    localparam logic [4:0]      STY      = 5'(START_Y);
    localparam logic [5:0]      EXX      = 6'(EXIT_X);
    localparam logic [4:0]      EXY      = 5'(EXIT_Y);

    typedef enum logic [2:0] {
        INIT_DRAW = 3'd0,
        IDLE      = 3'd1,
        LOOKUP    = 3'd2,
        ERASE     = 3'd3,
        DRAW      = 3'd4,
        WON       = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    pos_x_q, pos_x_d, tgt_x_q, tgt_x_d, wall_x_q, wall_x_d, draw_x_q, draw_x_d;
    logic [4:0]    pos_y_q, pos_y_d, tgt_y_q, tgt_y_d, wall_y_q, wall_y_d, draw_y_q, draw_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          draw_req_q, draw_req_d, draw_erase_q, draw_erase_d;
    logic          busy_q, busy_d, won_q, won_d;
    logic          step_ok;
    logic [5:0]    nx;
    logic [4:0]    ny;

    // Candidate target for the requested direction; edge cells never wrap, the move is just rejected.
    always_comb begin
        step_ok = 1'b0;
        nx      = pos_x_q;
        ny      = pos_y_q;
        case (dir)
            4'b1000: if (pos_y_q != 5'd0) begin step_ok = 1'b1; ny = pos_y_q - 5'd1; end
            4'b0100: if (pos_y_q < MAXY)  begin step_ok = 1'b1; ny = pos_y_q + 5'd1; end
            4'b0010: if (pos_x_q != 6'd0) begin step_ok = 1'b1; nx = pos_x_q - 6'd1; end
            4'b0001: if (pos_x_q < MAXX)  begin step_ok = 1'b1; nx = pos_x_q + 6'd1; end
            default: step_ok = 1'b0;
        endcase
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        wall_x_d     = wall_x_q;
        wall_y_d     = wall_y_q;
        cnt_d        = cnt_q;
        draw_req_d   = draw_req_q;
        draw_erase_d = draw_erase_q;
        draw_x_d     = draw_x_q;
        draw_y_d     = draw_y_q;
        case (state_q)
            INIT_DRAW: begin
                draw_req_d   = 1'b1;
                draw_erase_d = 1'b0;
                draw_x_d     = pos_x_q;
                draw_y_d     = pos_y_q;
                if (draw_req_q && draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            IDLE: begin
                draw_req_d = 1'b0;
                if (tick && step_ok) begin
                    tgt_x_d  = nx;
                    tgt_y_d  = ny;
                    wall_x_d = nx;
                    wall_y_d = ny;
                    cnt_d    = CNT_LOAD;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                // Counter reaching its last step marks the edge on which memory data is valid.
                if (cnt_q <= CW'(1)) begin
                    cnt_d = '0;
                    if (wall_data) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = ERASE;
                        draw_req_d   = 1'b1;
                        draw_erase_d = 1'b1;
                        draw_x_d     = pos_x_q;
                        draw_y_d     = pos_y_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ERASE: begin
                if (draw_req_q && draw_ack) begin
                    pos_x_d      = tgt_x_q;
                    pos_y_d      = tgt_y_q;
                    draw_req_d   = 1'b0;
                    draw_erase_d = 1'b0;
                    draw_x_d     = tgt_x_q;
                    draw_y_d     = tgt_y_q;
                    state_d      = DRAW;
                end
            end
            DRAW: begin
                // First DRAW cycle has req low so the drawer sees a clean gap after the erase ack.
                if (draw_req_q && draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = (pos_x_q == EXX && pos_y_q == EXY) ? WON : IDLE;
                end else begin
                    draw_req_d = 1'b1;
                end
            end
            WON: begin
                draw_req_d = 1'b0;
            end
            default: begin
                state_d = INIT_DRAW;
            end
        endcase
        busy_d = !(state_d == IDLE || state_d == WON);
        won_d  = (state_d == WON);
    end

    // State and output registers; synchronous reset overrides everything, including open handshakes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= INIT_DRAW;
            pos_x_q      <= STX;
            pos_y_q      <= STY;
            tgt_x_q      <= STX;
            tgt_y_q      <= STY;
            wall_x_q     <= 6'd0;
            wall_y_q     <= 5'd0;
            cnt_q        <= '0;
            draw_req_q   <= 1'b1;
            draw_erase_q <= 1'b0;
            draw_x_q     <= STX;
            draw_y_q     <= STY;
            busy_q       <= 1'b1;
            won_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            wall_x_q     <= wall_x_d;
            wall_y_q     <= wall_y_d;
            cnt_q        <= cnt_d;
            draw_req_q   <= draw_req_d;
            draw_erase_q <= draw_erase_d;
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            busy_q       <= busy_d;
            won_q        <= won_d;
        end
    end

    assign wall_x     = wall_x_q;
    assign wall_y     = wall_y_q;
    assign draw_req   = draw_req_q;
    assign draw_erase = draw_erase_q;
    assign draw_x     = draw_x_q;
    assign draw_y     = draw_y_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign busy       = busy_q;
    assign won        = won_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: move table on a default instance, corner sequences on both instances.
// Instance a starts at (0,0); instance b starts at (38,29), one step from the exit.
// Wall data is driven opposite to the intended value until the cycle it must be sampled.
module tb_player_move_ctrl;

    localparam int LAT = 2;

    logic       clock;
    logic       resetn, tick, wall_data, draw_ack;
    logic [3:0] dir;
    logic [5:0] wall_x, draw_x, pos_x;
    logic [4:0] wall_y, draw_y, pos_y;
    logic       draw_req, draw_erase, busy, won;

    logic       resetn_b, tick_b, wall_data_b, draw_ack_b;
    logic [3:0] dir_b;
    logic [5:0] wall_x_b, draw_x_b, pos_x_b;
    logic [4:0] wall_y_b, draw_y_b, pos_y_b;
    logic       draw_req_b, draw_erase_b, busy_b, won_b;

    int n_vec = 0;
    int n_bad = 0;

    player_move_ctrl #(.MEM_LATENCY(LAT)) u_dut (
        .clock(clock), .resetn(resetn), .tick(tick), .dir(dir),
        .wall_x(wall_x), .wall_y(wall_y), .wall_data(wall_data),
        .draw_req(draw_req), .draw_erase(draw_erase), .draw_x(draw_x), .draw_y(draw_y),
        .draw_ack(draw_ack), .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .won(won)
    );

    player_move_ctrl #(.START_X(38), .START_Y(29), .MEM_LATENCY(LAT)) u_dut_b (
        .clock(clock), .resetn(resetn_b), .tick(tick_b), .dir(dir_b),
        .wall_x(wall_x_b), .wall_y(wall_y_b), .wall_data(wall_data_b),
        .draw_req(draw_req_b), .draw_erase(draw_erase_b), .draw_x(draw_x_b), .draw_y(draw_y_b),
        .draw_ack(draw_ack_b), .pos_x(pos_x_b), .pos_y(pos_y_b), .busy(busy_b), .won(won_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] dir;
        logic       wall;
        logic       lookup;
        int         tx;
        int         ty;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vt[10];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cur_x, cur_y;
        logic moved;

        //                 dir      wall  lookup tx ty ex ey
        vt[0] = '{4'b0001, 1'b0, 1'b1, 1, 0, 1, 0};
        vt[1] = '{4'b0100, 1'b1, 1'b1, 1, 1, 1, 0};
        vt[2] = '{4'b0100, 1'b0, 1'b1, 1, 1, 1, 1};
        vt[3] = '{4'b0010, 1'b0, 1'b1, 0, 1, 0, 1};
        vt[4] = '{4'b0010, 1'b0, 1'b0, 0, 0, 0, 1};
        vt[5] = '{4'b1000, 1'b0, 1'b1, 0, 0, 0, 0};
        vt[6] = '{4'b1000, 1'b0, 1'b0, 0, 0, 0, 0};
        vt[7] = '{4'b0011, 1'b0, 1'b0, 0, 0, 0, 0};
        vt[8] = '{4'b0000, 1'b0, 1'b0, 0, 0, 0, 0};
        vt[9] = '{4'b0001, 1'b1, 1'b1, 1, 0, 0, 0};

        resetn = 1'b0; tick = 1'b0; dir = 4'b0000; wall_data = 1'b0; draw_ack = 1'b0;
        resetn_b = 1'b0; tick_b = 1'b0; dir_b = 4'b0000; wall_data_b = 1'b0; draw_ack_b = 1'b0;

        // Reset state of instance a.
        step(); step();
        chk("rst_req", draw_req, 1);
        chk("rst_erase", draw_erase, 0);
        chk("rst_draw_x", draw_x, 0);
        chk("rst_draw_y", draw_y, 0);
        chk("rst_busy", busy, 1);
        chk("rst_won", won, 0);
        chk("rst_pos_x", pos_x, 0);
        chk("rst_wall_x", wall_x, 0);

        // Tick on the same cycle reset is released: must be dropped.
        resetn = 1'b1; tick = 1'b1; dir = 4'b0001;
        step();
        tick = 1'b0; dir = 4'b0000;
        chk("init_req", draw_req, 1);
        chk("init_wall_x", wall_x, 0);
        step(); step();
        chk("init_req_held", draw_req, 1);
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        chk("init_req_drop", draw_req, 0);
        chk("init_busy", busy, 0);
        chk("init_pos_x", pos_x, 0);
        step();
        chk("init_no_lookup", busy, 0);

        // Move table.
        cur_x = 0; cur_y = 0;
        for (int i = 0; i < 10; i++) begin
            moved = vt[i].lookup && !vt[i].wall;
            tick = 1'b1; dir = vt[i].dir; wall_data = ~vt[i].wall;
            step();
            tick = 1'b0;
            chk("mv_busy", busy, vt[i].lookup);
            if (vt[i].lookup) begin
                chk("mv_wall_x", wall_x, vt[i].tx);
                chk("mv_wall_y", wall_y, vt[i].ty);
            end
            for (int k = 1; k < LAT; k++) begin
                if (k == LAT - 1) wall_data = vt[i].wall;
                step();
                if (vt[i].lookup) begin
                    chk("mv_wall_x_hold", wall_x, vt[i].tx);
                    chk("mv_wall_y_hold", wall_y, vt[i].ty);
                end
            end
            step();
            chk("mv_req", draw_req, moved);
            chk("mv_busy_after", busy, moved);
            if (moved) begin
                chk("mv_erase", draw_erase, 1);
                chk("mv_erase_x", draw_x, cur_x);
                chk("mv_erase_y", draw_y, cur_y);
                draw_ack = 1'b1;
                step();
                draw_ack = 1'b0;
                chk("mv_gap", draw_req, 0);
                step();
                chk("mv_draw_req", draw_req, 1);
                chk("mv_draw_erase", draw_erase, 0);
                chk("mv_draw_x", draw_x, vt[i].ex);
                chk("mv_draw_y", draw_y, vt[i].ey);
                draw_ack = 1'b1;
                step();
                draw_ack = 1'b0;
                chk("mv_done_busy", busy, 0);
            end
            chk("mv_pos_x", pos_x, vt[i].ex);
            chk("mv_pos_y", pos_y, vt[i].ey);
            chk("mv_req_end", draw_req, 0);
            cur_x = vt[i].ex;
            cur_y = vt[i].ey;
        end

        // Stalled erase with ticks arriving: outputs stay stable and ticks are dropped.
        tick = 1'b1; dir = 4'b0001; wall_data = 1'b0;
        step();
        tick = 1'b0;
        repeat (LAT) step();
        for (int i = 0; i < 10; i++) begin
            tick = (i % 2 == 0); dir = 4'b0100;
            step();
            chk("stall_req", draw_req, 1);
            chk("stall_erase", draw_erase, 1);
            chk("stall_x", draw_x, 0);
            chk("stall_y", draw_y, 0);
            chk("stall_pos_x", pos_x, 0);
        end
        tick = 1'b0;
        draw_ack = 1'b1;
        step();
        chk("stall_gap", draw_req, 0);
        chk("stall_pos_upd", pos_x, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ack_ignored_req", draw_req, 1);
        chk("ack_ignored_busy", busy, 1);
        chk("ack_ignored_x", draw_x, 1);
        step();
        draw_ack = 1'b0;
        chk("stall_done_req", draw_req, 0);
        repeat (4) step();
        chk("stall_idle", busy, 0);
        chk("stall_pos_x_end", pos_x, 1);
        chk("stall_pos_y_end", pos_y, 0);
        chk("stall_wall_x", wall_x, 1);
        chk("stall_wall_y", wall_y, 0);

        // Instance b: reach the exit.
        step();
        resetn_b = 1'b1;
        step();
        chk("b_init_req", draw_req_b, 1);
        chk("b_init_x", draw_x_b, 38);
        chk("b_init_y", draw_y_b, 29);
        draw_ack_b = 1'b1;
        step();
        draw_ack_b = 1'b0;
        chk("b_idle", busy_b, 0);
        tick_b = 1'b1; dir_b = 4'b0001;
        step();
        tick_b = 1'b0;
        repeat (LAT) step();
        chk("b_erase_req", draw_req_b, 1);
        chk("b_erase", draw_erase_b, 1);
        draw_ack_b = 1'b1;
        step();
        chk("b_gap", draw_req_b, 0);
        step();
        chk("b_draw_req", draw_req_b, 1);
        step();
        draw_ack_b = 1'b0;
        chk("b_won", won_b, 1);
        chk("b_won_busy", busy_b, 0);
        chk("b_pos_x", pos_x_b, 39);
        chk("b_pos_y", pos_y_b, 29);
        for (int i = 0; i < 4; i++) begin
            tick_b = 1'b1; dir_b = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            step();
            tick_b = 1'b0;
            step();
            chk("b_won_sticky", won_b, 1);
            chk("b_won_pos", pos_x_b, 39);
            chk("b_won_req", draw_req_b, 0);
            chk("b_won_busy_sticky", busy_b, 0);
        end

        // Reset out of WON, then reset in the middle of an erase handshake.
        resetn_b = 1'b0;
        step();
        resetn_b = 1'b1;
        chk("b_rst_won", won_b, 0);
        chk("b_rst_pos_x", pos_x_b, 38);
        chk("b_rst_req", draw_req_b, 1);
        draw_ack_b = 1'b1;
        step();
        draw_ack_b = 1'b0;
        tick_b = 1'b1; dir_b = 4'b0001;
        step();
        tick_b = 1'b0;
        repeat (LAT) step();
        chk("b2_erase", draw_erase_b, 1);
        resetn_b = 1'b0; draw_ack_b = 1'b1;
        step();
        resetn_b = 1'b1; draw_ack_b = 1'b0;
        chk("b2_pos_x", pos_x_b, 38);
        chk("b2_pos_y", pos_y_b, 29);
        chk("b2_won", won_b, 0);
        chk("b2_req", draw_req_b, 1);
        chk("b2_erase_clr", draw_erase_b, 0);
        chk("b2_draw_x", draw_x_b, 38);
        chk("b2_busy", busy_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameters SHALL be: MAX_X, default 39, last legal column; MAX_Y, default 29, last legal row; START_X/START_Y, default 0/0, position after reset; EXIT_X/EXIT_Y, default 39/29, goal cell; MEM_LATENCY, default 2, wall-memory read latency in cycles (minimum 1).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 tick  in  1  one-cycle move pulse from the rate divider (8 Hz).
REQ-005 dir  in  4  {up,down,left,right}; sampled only on an accepted tick.
REQ-006 wall_x / wall_y  out  6 / 5  cell address to wall memory.
REQ-007 wall_data  in  1  1 = wall; valid MEM_LATENCY cycles after the address.
REQ-008 draw_req  out  1  plot request to the VGA drawer.
REQ-009 draw_erase  out  1  1 = erase cell, 0 = draw player.
REQ-010 draw_x / draw_y  out  6 / 5  cell to plot.
REQ-011 draw_ack  in  1  drawer accepts the current request.
REQ-012 pos_x / pos_y  out  6 / 5  current player cell.
REQ-013 busy  out  1  high in every state except IDLE and WON.
REQ-014 won  out  1  sticky; player has reached the exit.

Function
REQ-015 FSM states SHALL be INIT_DRAW, IDLE, LOOKUP, ERASE, DRAW, WON.
REQ-016 INIT_DRAW: draw_req=1, draw_erase=0, draw_x/y=pos; on draw_ack -> IDLE.
REQ-017 IDLE: tick with dir exactly one-hot and target inside 0..MAX_X / 0..MAX_Y -> register target, drive wall_x/y=target from the next cycle, -> LOOKUP; otherwise the tick SHALL be discarded and the FSM stays in IDLE.
REQ-018 Target SHALL be pos with y-1 (up), y+1 (down), x-1 (left) or x+1 (right); out-of-range targets SHALL never be computed with wrap-around.
REQ-019 LOOKUP: a down-counter SHALL hold wall_x/y stable and sample wall_data on the MEM_LATENCY-th rising edge after entry; wall_data=1 -> IDLE with pos unchanged, wall_data=0 -> ERASE.
REQ-020 ERASE: draw_req=1, draw_erase=1, draw_x/y=old pos; on draw_ack pos SHALL update to target on the same edge -> DRAW.
REQ-021 DRAW: draw_req=1, draw_erase=0, draw_x/y=new pos; on draw_ack -> WON if pos==(EXIT_X,EXIT_Y), else IDLE.
REQ-022 Handshake: draw_req, draw_erase and draw_x/y SHALL remain stable while draw_req=1 and draw_ack=0; draw_req SHALL be 0 on the cycle after the ack edge; draw_ack while draw_req=0 SHALL be ignored.
REQ-023 A tick arriving in any state other than IDLE SHALL be dropped, not queued.
REQ-024 WON: won=1, busy=0, draw_req=0; all ticks ignored until reset.
REQ-025 An accepted move SHALL take exactly 1 + MEM_LATENCY cycles to reach ERASE; total latency also includes the ack waits.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On a clock edge with resetn=0: state=INIT_DRAW, pos=(START_X,START_Y), won=0, wall_x/y=0, LOOKUP counter=0.
REQ-028 Reset values after that edge: draw_req=1, draw_erase=0, draw_x/y=start, busy=1.
REQ-029 Reset SHALL take priority over every other input in any state, including mid-handshake and mid-LOOKUP; a pending request SHALL be abandoned.
REQ-030 If resetn returns high in the same cycle as tick, the tick SHALL be dropped, because the FSM is in INIT_DRAW.

Verification
REQ-031 Reset, then ack after 3 cycles -> one draw_req at (0,0), erase=0; busy falls and the FSM is in IDLE.
REQ-032 From (0,0), tick with dir=0001 and wall_data=0 -> wall addr (1,0) for 2 cycles; erase (0,0) then draw (1,0); pos=(1,0).
REQ-033 Tick with wall_data=1 -> no draw_req; pos unchanged; FSM in IDLE after 3 cycles.
REQ-034 At (0,0) with dir=1000 (up), dir=0011, or dir=0000 -> no lookup, no draw_req, pos unchanged.
REQ-035 Hold draw_ack low for 10 cycles during ERASE while pulsing tick -> req, x/y and erase stay stable; the ticks are dropped; exactly one move occurs.
REQ-036 With START=(38,29), move right -> pos=(39,29); won=1 and stays high through later ticks; resetn=0 mid-ERASE in a later run -> pos=(38,29), won=0, INIT_DRAW.
